// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: source ids, default widths, round-robin helper.
// Optional feature macro used by this block: CDB_BYPASS_EN.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_N_SRC  = 3;
    localparam int unsigned CDB_ROB_W  = 4;   // same width as the ROB index range
    localparam int unsigned CDB_DATA_W = 32;

    localparam int unsigned CDB_SRC_ALU   = 0;
    localparam int unsigned CDB_SRC_LSB   = 1;
    localparam int unsigned CDB_SRC_SPARE = 2;

    function automatic int unsigned cdb_rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshake and CDB broadcast bundle of the CDB arbiter.
// master = producers/consumers side, slave = arbiter side.
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(
    parameter int unsigned N_SRC  = CDB_N_SRC,
    parameter int unsigned ROB_W  = CDB_ROB_W,
    parameter int unsigned DATA_W = CDB_DATA_W
);
    localparam int unsigned SrcW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]        src_valid_in;
    logic [N_SRC-1:0]        src_ready_out;
    logic [N_SRC*ROB_W-1:0]  src_rob_idx_in;
    logic [N_SRC*DATA_W-1:0] src_value_in;

    logic                    CDB_flag;
    logic [ROB_W-1:0]        CDB_ROB_idx;
    logic [DATA_W-1:0]       CDB_value;
    logic [SrcW-1:0]         CDB_src;

    modport master (
        output src_valid_in, src_rob_idx_in, src_value_in,
        input  src_ready_out, CDB_flag, CDB_ROB_idx, CDB_value, CDB_src
    );

    modport slave (
        input  src_valid_in, src_rob_idx_in, src_value_in,
        output src_ready_out, CDB_flag, CDB_ROB_idx, CDB_value, CDB_src
    );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i (mod N) wins.
module cdb_arbiter_rr_picker #(
    parameter int unsigned N = 3,
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [PtrW-1:0] idx_o,
    output logic            any_o
);

    always_comb begin
        int unsigned j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = PtrW'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-producer one-entry holding buffers, round-robin grant, registered broadcast.
// Define CDB_BYPASS_EN to let an empty-buffer source with a valid input compete directly.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
    parameter int unsigned N_SRC  = CDB_N_SRC,
    parameter int unsigned ROB_W  = CDB_ROB_W,
    parameter int unsigned DATA_W = CDB_DATA_W
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         rdy_in,
    input  logic         flush_in,
    cdb_arbiter_if.slave bus
);

    localparam int unsigned SrcW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0]  buf_valid_q, buf_valid_d;
    logic [ROB_W-1:0]  buf_rob_q [N_SRC];
    logic [ROB_W-1:0]  buf_rob_d [N_SRC];
    logic [DATA_W-1:0] buf_val_q [N_SRC];
    logic [DATA_W-1:0] buf_val_d [N_SRC];
    logic [SrcW-1:0]   rr_ptr_q, rr_ptr_d;

    logic              cdb_flag_q, cdb_flag_d;
    logic [ROB_W-1:0]  cdb_idx_q, cdb_idx_d;
    logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
    logic [SrcW-1:0]   cdb_src_q, cdb_src_d;

    logic [N_SRC-1:0]  cand, gnt, accept;
    logic [SrcW-1:0]   win;
    logic              any_win;
    logic              go;

    assign go = rdy_in && !flush_in;

`ifdef CDB_BYPASS_EN
    assign cand = buf_valid_q | bus.src_valid_in;
`else
    assign cand = buf_valid_q;
`endif

    cdb_arbiter_rr_picker #(
        .N (N_SRC)
    ) u_picker (
        .req_i (cand),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (win),
        .any_o (any_win)
    );

    assign bus.src_ready_out = flush_in ? '0 : (~buf_valid_q | (gnt & {N_SRC{rdy_in}}));
    assign accept            = bus.src_valid_in & bus.src_ready_out & {N_SRC{go}};

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_rob_d   = buf_rob_q;
        buf_val_d   = buf_val_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_flag_d  = cdb_flag_q;
        cdb_idx_d   = cdb_idx_q;
        cdb_val_d   = cdb_val_q;
        cdb_src_d   = cdb_src_q;
        if (flush_in) begin
            buf_valid_d = '0;
            cdb_flag_d  = 1'b0;
            rr_ptr_d    = '0;
        end else if (rdy_in) begin
            cdb_flag_d = any_win;
            if (any_win) begin
                cdb_src_d = win;
                rr_ptr_d  = SrcW'(cdb_rr_next(int'(win), N_SRC));
                if (buf_valid_q[win]) begin
                    cdb_idx_d = buf_rob_q[win];
                    cdb_val_d = buf_val_q[win];
                end else begin
                    cdb_idx_d = bus.src_rob_idx_in[win*ROB_W +: ROB_W];
                    cdb_val_d = bus.src_value_in[win*DATA_W +: DATA_W];
                end
            end
            for (int unsigned i = 0; i < N_SRC; i++) begin
                // A granted empty buffer means the input went straight to the CDB.
                if (accept[i] && !(gnt[i] && !buf_valid_q[i])) begin
                    buf_valid_d[i] = 1'b1;
                    buf_rob_d[i]   = bus.src_rob_idx_in[i*ROB_W +: ROB_W];
                    buf_val_d[i]   = bus.src_value_in[i*DATA_W +: DATA_W];
                end else if (gnt[i]) begin
                    buf_valid_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            buf_valid_q <= '0;
            buf_rob_q   <= '{default: '0};
            buf_val_q   <= '{default: '0};
            rr_ptr_q    <= '0;
            cdb_flag_q  <= 1'b0;
            cdb_idx_q   <= '0;
            cdb_val_q   <= '0;
            cdb_src_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_rob_q   <= buf_rob_d;
            buf_val_q   <= buf_val_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_flag_q  <= cdb_flag_d;
            cdb_idx_q   <= cdb_idx_d;
            cdb_val_q   <= cdb_val_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign bus.CDB_flag    = cdb_flag_q;
    assign bus.CDB_ROB_idx = cdb_idx_q;
    assign bus.CDB_value   = cdb_val_q;
    assign bus.CDB_src     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios then random traffic against a
// per-source buffer model with round-robin selection.
module tb_cdb_arbiter;

    localparam int N = 3;
`ifdef CDB_BYPASS_EN
    localparam int Lat = 1;
`else
    localparam int Lat = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus for the next cycle
    logic [2:0]  t_v;
    logic [3:0]  t_rob [3];
    logic [31:0] t_val [3];
    logic        t_rdy;
    logic        t_flush;

    // Reference model state
    bit          m_bv [3];
    logic [3:0]  m_rob [3];
    logic [31:0] m_val [3];
    int          m_ptr;
    logic        m_flag;
    logic [3:0]  m_idx;
    logic [31:0] m_value;
    logic [1:0]  m_src;
    int          m_win;
    logic [2:0]  m_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_bv[i]  = 1'b0;
            m_rob[i] = '0;
            m_val[i] = '0;
        end
        m_ptr = 0; m_flag = 1'b0; m_idx = '0; m_value = '0; m_src = '0;
    endtask

    task automatic model_comb();
        bit cand;
        m_win = -1;
        for (int k = 0; k < N; k++) begin
            int j = (m_ptr + k) % N;
            cand = m_bv[j];
`ifdef CDB_BYPASS_EN
            cand = cand || t_v[j];
`endif
            if (cand && m_win < 0) m_win = j;
        end
        for (int i = 0; i < N; i++)
            m_ready[i] = !t_flush && (!m_bv[i] || (m_win == i && t_rdy));
    endtask

    task automatic model_edge();
        bit acc [3];
        if (t_flush) begin
            for (int i = 0; i < N; i++) m_bv[i] = 1'b0;
            m_flag = 1'b0;
            m_ptr  = 0;
        end else if (t_rdy) begin
            for (int i = 0; i < N; i++) acc[i] = t_v[i] && m_ready[i];
            m_flag = (m_win >= 0);
            if (m_win >= 0) begin
                m_src = 2'(m_win);
                if (m_bv[m_win]) begin
                    m_idx = m_rob[m_win]; m_value = m_val[m_win];
                end else begin
                    m_idx = t_rob[m_win]; m_value = t_val[m_win];
                end
                m_ptr = (m_win + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i] && !(i == m_win && !m_bv[i])) begin
                    m_bv[i] = 1'b1; m_rob[i] = t_rob[i]; m_val[i] = t_val[i];
                end else if (i == m_win) begin
                    m_bv[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_cdb(input string tag);
        chk({tag, ".flag"}, 32'(bus.CDB_flag), 32'(m_flag));
        chk({tag, ".idx"},  32'(bus.CDB_ROB_idx), 32'(m_idx));
        chk({tag, ".val"},  bus.CDB_value, m_value);
        chk({tag, ".src"},  32'(bus.CDB_src), 32'(m_src));
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        bus.src_valid_in   = t_v;
        bus.src_rob_idx_in = {t_rob[2], t_rob[1], t_rob[0]};
        bus.src_value_in   = {t_val[2], t_val[1], t_val[0]};
        rdy   = t_rdy;
        flush = t_flush;
        #1;
        model_comb();
        chk({tag, ".ready"}, 32'(bus.src_ready_out), 32'(m_ready));
        @(posedge clk);
        model_edge();
        #1;
        check_cdb(tag);
    endtask

    task automatic idle();
        t_v = '0; t_rdy = 1'b1; t_flush = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin t_rob[i] = '0; t_val[i] = '0; end
        t_v = '0; t_rdy = 1'b0; t_flush = 1'b0;
        bus.src_valid_in = '0; bus.src_rob_idx_in = '0; bus.src_value_in = '0;
        model_reset();
        #1;
        check_cdb("reset");
        chk("reset.ready", 32'(bus.src_ready_out), 32'h7);
        #11 rst_n = 1'b1;

        // Single result from the LSB port
        idle();
        t_v = 3'b010; t_rob[1] = 4'd5; t_val[1] = 32'hDEAD_BEEF;
        cycle("single.req");
        idle();
        for (int c = 1; c < Lat; c++) cycle("single.wait");
        chk("single.flag", 32'(bus.CDB_flag), 32'h1);
        chk("single.idx", 32'(bus.CDB_ROB_idx), 32'h5);
        chk("single.val", bus.CDB_value, 32'hDEAD_BEEF);
        chk("single.src", 32'(bus.CDB_src), 32'h1);
        cycle("single.after");
        chk("single.pulse", 32'(bus.CDB_flag), 32'h0);

        // Contention from rr_ptr = 0
        t_flush = 1'b1; cycle("cont.clr"); idle();
        t_v = 3'b111;
        t_rob[0] = 4'd1; t_rob[1] = 4'd2; t_rob[2] = 4'd3;
        t_val[0] = 32'h11; t_val[1] = 32'h22; t_val[2] = 32'h33;
        cycle("cont.req");
        idle();
        for (int c = 1; c < Lat; c++) cycle("cont.wait");
        chk("cont.first", 32'(bus.CDB_ROB_idx), 32'h1);
        cycle("cont.b2");
        chk("cont.second", 32'(bus.CDB_ROB_idx), 32'h2);
        cycle("cont.b3");
        chk("cont.third", 32'(bus.CDB_ROB_idx), 32'h3);
        cycle("cont.done");

        // Back-to-back stream from the ALU
        for (int k = 0; k < 4; k++) begin
            idle(); t_v = 3'b001; t_rob[0] = 4'(8 + k); t_val[0] = 32'hA000 + k;
            cycle("b2b.req");
            chk("b2b.ready0", 32'(bus.src_ready_out[0]), 32'h1);
        end
        idle();
        repeat (3) cycle("b2b.drain");

        // Flush with buffers 0 and 2 occupied; src1 request on the flush cycle is dropped
        idle(); t_v = 3'b101; t_rob[0] = 4'd6; t_rob[2] = 4'd7;
        cycle("flush.fill");
        idle(); t_flush = 1'b1; t_v = 3'b010; t_rob[1] = 4'd9;
        cycle("flush.clr");
        chk("flush.flag", 32'(bus.CDB_flag), 32'h0);
        idle();
        repeat (3) cycle("flush.quiet");

        // Freeze with src1 buffered
        idle(); t_v = 3'b010; t_rob[1] = 4'd12; t_val[1] = 32'h0BAD_F00D;
        cycle("frz.fill");
        idle(); t_rdy = 1'b0;
        repeat (3) cycle("frz.hold");
        idle();
        cycle("frz.resume");

        // Async reset while CDB_flag is high
        idle(); t_v = 3'b100; t_rob[2] = 4'd14; t_val[2] = 32'h1234_5678;
        cycle("arst.req");
        idle();
        for (int c = 1; c < Lat; c++) cycle("arst.wait");
        chk("arst.pre", 32'(bus.CDB_flag), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.flag", 32'(bus.CDB_flag), 32'h0);
        check_cdb("arst");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            t_v     = 3'($urandom);
            t_rdy   = ($urandom % 8) != 0;
            t_flush = ($urandom % 32) == 0;
            for (int i = 0; i < N; i++) begin
                t_rob[i] = 4'($urandom);
                t_val[i] = $urandom;
            end
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
